rr_arbiter16: RTL and testbench
===============================

// Module: rr_arbiter16
// PURPOSE
//  Round-robin arbiter sharing one resource among 16 requesters. Picks the next
//  requester at or after a rotating priority pointer, encodes the winner as a
//  4-bit index and drives a 16-bit one-hot grant (index-to-one-hot decode).
//  Holds the grant until the owner signals done, drops its request, or a hold
//  timeout expires. Sits in front of any shared datapath resource.
// PARAMETERS
//  MAX_HOLD  8  max cycles a grant is held in GRANT; 0 = no timeout
//  CNTW      8  width of hold counter; MAX_HOLD must be < 2**CNTW
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  rst        in   1   asynchronous, active-high reset
//  req        in   16  request vector, bit i = requester i
//  done       in   1   owner releases the grant (single-cycle pulse)
//  gnt        out  16  one-hot grant, registered; all-zero when none granted
//  gnt_idx    out  4   index of granted requester, registered; 0 when idle
//  gnt_valid  out  1   high while a grant is held (== |gnt)
//  timeout    out  1   1-cycle pulse when a grant is revoked by MAX_HOLD
// BEHAVIOUR
//  Reset: gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE.
//  Reset asserted mid-grant clears all of the above immediately (async).
//  FSM states: IDLE, GRANT.
//  IDLE: if req!=0 at edge, winner = first i in order ptr, ptr+1, ..., 15, 0,
//   ..., ptr-1 (mod 16) with req[i]=1; next cycle gnt[winner]=1,
//   gnt_idx=winner, gnt_valid=1, hold_cnt=1, state->GRANT. req==0: stay.
//  Latency: req sampled at edge k -> gnt visible after edge k+1 (1 cycle).
//  GRANT: release at an edge when any of: done=1; req[gnt_idx]=0;
//   MAX_HOLD!=0 and hold_cnt==MAX_HOLD. Else hold_cnt++ (saturates at all-ones).
//  Release: gnt=0, gnt_valid=0, gnt_idx=0, ptr=(released_idx+1) mod 16
//   (15 wraps to 0), state->IDLE. Exactly one IDLE cycle between grants.
//  timeout pulses 1 cycle, coincident with release, only if the release is
//   due to the MAX_HOLD condition alone (done=0 and req[gnt_idx]=1).
//  Simultaneous done and timeout on same edge: treated as done, timeout=0.
//  Requests of other bits while in GRANT are ignored (no preemption).
//  gnt is always one-hot or zero; gnt == (1<<gnt_idx) whenever gnt_valid=1.
//  done in IDLE is ignored.
// TESTING
//  1 Reset, req=16'h0001 -> gnt=16'h0001, gnt_idx=0 one cycle after sampling;
//    done pulse -> gnt=0 next cycle, ptr=1.
//  2 req=16'hFFFF held, done pulsed each GRANT cycle -> grant order
//    0,1,...,15,0 with one zero-gnt cycle between each (wrap at 15->0).
//  3 ptr=5, req=16'h0011 -> winner 0 (wrap search); then ptr=1, next winner 4.
//  4 MAX_HOLD=8, req=16'h0008 held, no done -> gnt=16'h0008 for exactly 8
//    cycles, timeout=1 on release cycle, ptr=4.
//  5 During grant to 3, drop req[3] -> release next edge, timeout=0;
//    same-edge done + timeout -> timeout stays 0.
//  6 Assert rst mid-GRANT (gnt=16'h0400) -> all outputs 0 immediately, ptr=0;
//    after release req=16'h0400 -> grant 10 again after 1 cycle.

Source files
------------

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters with one-hot and indexed grant outputs.
// A grant is held until done, request drop, or a MAX_HOLD-cycle timeout.
module rr_arbiter16 #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNTW     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_idx,
    output logic        gnt_valid,
    output logic        timeout
);

    localparam int unsigned NREQ = 16;
    localparam int unsigned IDXW = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [IDXW-1:0]   ptr, ptr_nxt;
    logic [CNTW-1:0]   hold_cnt, hold_nxt;
    logic [NREQ-1:0]   gnt_nxt;
    logic [IDXW-1:0]   idx_nxt;
    logic              valid_nxt;
    logic              timeout_nxt;

    logic              found;
    logic [IDXW-1:0]   win;
    logic [IDXW-1:0]   cand;
    logic              hold_expired;
    logic              owner_req;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            gnt       <= gnt_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

    // Winner search, release detection and next-state logic
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        gnt_nxt     = gnt;
        idx_nxt     = gnt_idx;
        valid_nxt   = gnt_valid;
        timeout_nxt = 1'b0;
        found       = 1'b0;
        win         = '0;
        cand        = '0;

        // First requester at or after ptr; 4-bit addition wraps 15 -> 0
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = ptr + IDXW'(off);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end

        hold_expired = (MAX_HOLD != 0) && (hold_cnt == CNTW'(MAX_HOLD));
        owner_req    = req[gnt_idx];

        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                    gnt_nxt   = NREQ'(1) << win;
                    idx_nxt   = win;
                    valid_nxt = 1'b1;
                    hold_nxt  = CNTW'(1);
                end
            end
            GRANT: begin
                if (done || !owner_req || hold_expired) begin
                    state_nxt   = IDLE;
                    gnt_nxt     = '0;
                    idx_nxt     = '0;
                    valid_nxt   = 1'b0;
                    ptr_nxt     = gnt_idx + IDXW'(1);
                    // done or a dropped request take precedence over the timeout
                    timeout_nxt = hold_expired && !done && owner_req;
                end else if (hold_cnt != '1) begin
                    hold_nxt = hold_cnt + CNTW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed and randomized checks of rr_arbiter16 against a behavioural
// round-robin model (owner index, priority pointer, hold count as integers).
module tb_rr_arbiter16;

    localparam int MAX_HOLD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    // Reference model: owner = -1 when nothing is granted
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_timeout;

    rr_arbiter16 #(.MAX_HOLD(MAX_HOLD), .CNTW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_ptr     = 0;
        m_hold    = 0;
        m_timeout = 1'b0;
    endtask

    // Advance the model by one clock edge using the current inputs
    task automatic model_edge();
        bit expired;
        m_timeout = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < 16; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % 16]) begin
                    m_owner = (m_ptr + k) % 16;
                    m_hold  = 1;
                end
            end
        end else begin
            expired = (MAX_HOLD != 0) && (m_hold == MAX_HOLD);
            if (done || !req[m_owner] || expired) begin
                m_timeout = expired && !done && req[m_owner];
                m_ptr     = (m_owner + 1) % 16;
                m_owner   = -1;
            end else if (m_hold < 255) begin
                m_hold++;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        logic [15:0] eg;
        logic [15:0] ei;
        eg = (m_owner >= 0) ? (16'h0001 << m_owner) : 16'h0000;
        ei = (m_owner >= 0) ? 16'(m_owner) : 16'h0000;
        check({tag, ".gnt"}, gnt, eg);
        check({tag, ".gnt_idx"}, {12'h000, gnt_idx}, ei);
        check({tag, ".gnt_valid"}, {15'h0000, gnt_valid}, {15'h0000, m_owner >= 0});
        check({tag, ".timeout"}, {15'h0000, timeout}, {15'h0000, m_timeout});
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_model("reset");
        rst = 1'b0;

        // 1: single requester, grant then done
        req = 16'h0001;
        step("t1_grant");
        check("t1_gnt", gnt, 16'h0001);
        done = 1'b1;
        step("t1_release");
        check("t1_gnt_zero", gnt, 16'h0000);
        done = 1'b0;
        req  = '0;
        step("t1_idle");

        // 2: all requesting, done each grant; ptr is 1 so order starts at 1 and wraps
        req = 16'hFFFF;
        for (int i = 0; i < 17; i++) begin
            step("t2_grant");
            check("t2_order", {12'h000, gnt_idx}, 16'((1 + i) % 16));
            done = 1'b1;
            step("t2_release");
            check("t2_gap", gnt, 16'h0000);
            done = 1'b0;
        end

        // 3: drive ptr to 5, then wrap search picks 0, then 4
        req = 16'h0010;
        step("t3_g4");
        done = 1'b1;
        step("t3_r4");
        done = 1'b0;
        req  = 16'h0011;
        step("t3_g0");
        check("t3_wrap_winner", {12'h000, gnt_idx}, 16'h0000);
        done = 1'b1;
        step("t3_r0");
        done = 1'b0;
        step("t3_g4b");
        check("t3_next_winner", {12'h000, gnt_idx}, 16'h0004);
        done = 1'b1;
        step("t3_r4b");
        done = 1'b0;

        // 4: held request with no done times out after exactly MAX_HOLD cycles
        req = 16'h0008;
        for (int i = 0; i < MAX_HOLD; i++) begin
            step("t4_hold");
            check("t4_gnt_held", gnt, 16'h0008);
        end
        step("t4_timeout");
        check("t4_timeout_pulse", {15'h0000, timeout}, 16'h0001);
        req = 16'h0018;
        step("t4_ptr");
        check("t4_ptr_is_4", {12'h000, gnt_idx}, 16'h0004);
        done = 1'b1;
        step("t4_release");
        done = 1'b0;

        // 5: request drop releases without timeout; done on the expiry edge wins
        req = 16'h0008;
        step("t5_g3");
        step("t5_hold");
        req = 16'h0000;
        step("t5_drop");
        check("t5_drop_no_timeout", {15'h0000, timeout}, 16'h0000);
        req = 16'h0008;
        for (int i = 0; i < MAX_HOLD; i++) step("t5_hold2");
        done = 1'b1;
        step("t5_done_vs_timeout");
        check("t5_done_wins", {15'h0000, timeout}, 16'h0000);
        done = 1'b0;
        req  = 16'h0000;
        step("t5_idle");

        // 6: async reset mid-grant clears outputs before the next edge
        req = 16'h0400;
        step("t6_g10");
        check("t6_gnt", gnt, 16'h0400);
        step("t6_hold");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_model("t6_async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("t6_regrant");
        check("t6_regrant_10", gnt, 16'h0400);
        done = 1'b1;
        step("t6_release");
        done = 1'b0;

        // Random: slowly changing requests so grants both release and time out
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0:       req = 16'($urandom);
                    1:       req = 16'h0001 << $urandom_range(0, 15);
                    default: req = '0;
                endcase
            end
            done = ($urandom_range(0, 5) == 0);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
